// File: rtl/load_store_unit.sv
// Data-memory initiator for RV32I loads and stores: word-wide accesses, lane extraction,
// sign/zero extension and read-modify-write for sub-word stores. One request in flight at a time.
module load_store_unit #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STORE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]        state_reg;
    logic              store_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       buf_reg;
    logic [31:0]       resp_rdata_reg;
    logic              resp_fault_reg;

    logic              illegal;
    logic [31:0]       lane_shifted;
    logic [31:0]       load_result;
    logic [31:0]       merged;
    logic [3:0]        lane_sel;
    logic              busy;

    // Legality is judged on the live request so a fault can go straight to RESP.
    always_comb begin
        illegal = 1'b0;
        if (req_store) begin
            illegal = (req_funct3 > 3'd2)
                   || (req_funct3 == 3'd1 && req_addr[0])
                   || (req_funct3 == 3'd2 && req_addr[1:0] != 2'b00);
        end else begin
            illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7)
                   || ((req_funct3 == 3'd1 || req_funct3 == 3'd5) && req_addr[0])
                   || (req_funct3 == 3'd2 && req_addr[1:0] != 2'b00);
        end
    end

    always_comb begin
        lane_shifted = mem_rdata >> {addr_reg[1:0], 3'b000};
        load_result  = lane_shifted;
        case (funct3_reg)
            3'd0:    load_result = {{24{lane_shifted[7]}}, lane_shifted[7:0]};
            3'd1:    load_result = {{16{lane_shifted[15]}}, lane_shifted[15:0]};
            3'd4:    load_result = {24'd0, lane_shifted[7:0]};
            3'd5:    load_result = {16'd0, lane_shifted[15:0]};
            default: load_result = mem_rdata;
        endcase
    end

    // funct3_reg[0] distinguishes sh (half lane) from sb (byte lane) in the merge.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_sel[gi] = funct3_reg[0] ? (addr_reg[1] == LANE[1])
                                                : (addr_reg[1:0] == LANE);
            assign merged[8*gi +: 8] = !lane_sel[gi] ? buf_reg[8*gi +: 8]
                                     : funct3_reg[0] ? wdata_reg[8*(gi%2) +: 8]
                                                     : wdata_reg[7:0];
        end
    endgenerate

    assign busy       = (state_reg == S_LOAD) || (state_reg == S_STORE)
                     || (state_reg == S_RMW_RD) || (state_reg == S_RMW_WR);
    assign req_ready  = (state_reg == S_IDLE) && !rst;
    assign mem_read   = ((state_reg == S_LOAD) || (state_reg == S_RMW_RD)) && !rst;
    assign mem_write  = ((state_reg == S_STORE) || (state_reg == S_RMW_WR)) && !rst;
    assign mem_addr   = busy ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata  = (state_reg == S_STORE)  ? wdata_reg
                      : (state_reg == S_RMW_WR) ? merged : 32'd0;
    assign resp_valid = (state_reg == S_RESP);
    assign resp_rdata = resp_rdata_reg;
    assign resp_fault = resp_fault_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            store_reg      <= 1'b0;
            funct3_reg     <= 3'd0;
            addr_reg       <= '0;
            wdata_reg      <= 32'd0;
            buf_reg        <= 32'd0;
            resp_rdata_reg <= 32'd0;
            resp_fault_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        store_reg      <= req_store;
                        funct3_reg     <= req_funct3;
                        addr_reg       <= req_addr;
                        wdata_reg      <= req_wdata;
                        resp_rdata_reg <= 32'd0;
                        resp_fault_reg <= illegal;
                        if (illegal)
                            state_reg <= S_RESP;
                        else if (!req_store)
                            state_reg <= S_LOAD;
                        else if (req_funct3 == 3'd2)
                            state_reg <= S_STORE;
                        else
                            state_reg <= S_RMW_RD;
                    end
                end
                S_LOAD: begin
                    resp_rdata_reg <= load_result;
                    state_reg      <= S_RESP;
                end
                S_STORE:  state_reg <= S_RESP;
                S_RMW_RD: begin
                    buf_reg   <= mem_rdata;
                    state_reg <= S_RMW_WR;
                end
                S_RMW_WR: state_reg <= S_RESP;
                S_RESP: begin
                    if (resp_ready)
                        state_reg <= S_IDLE;
                end
                default:  state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small combinational-read word memory behind it.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [8:0]  req_addr = 9'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:127];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write) mem[mem_addr[8:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[8:2]];

    load_store_unit #(.ADDR_W(9)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic do_op(input logic st, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                         output int lat, output logic saw_rd, output logic saw_wr);
        @(negedge clk);
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready: got %b want 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; saw_rd = 1'b0; saw_wr = 1'b0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            saw_rd |= mem_read; saw_wr |= mem_write;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat >= 20) begin
            errors++; $display("FAIL resp_timeout: no resp_valid after %0d cycles, want <=3", lat);
        end
        rd = resp_rdata; flt = resp_fault;
        $display("txn store=%0b f3=%0d addr=0x%03h wdata=0x%08h -> rdata=0x%08h fault=%0b lat=%0d",
                 st, f3, a, wd, rd, flt, lat);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0
            || resp_rdata !== 32'd0 || resp_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rv=%b mr=%b mw=%b rd=0x%08h f=%b want 0 all",
                     req_ready, resp_valid, mem_read, mem_write, resp_rdata, resp_fault);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || mem_addr !== 9'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL idle_after_reset: ready=%b addr=0x%03h wdata=0x%08h want 1/0/0",
                     req_ready, mem_addr, mem_wdata);
        end
        $display("txn reset released");
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic flt, sr, sw; int lat;
        do_op(1'b1, 3'd2, 9'h010, 32'hDEADBEEF, rd, flt, lat, sr, sw);
        checks++;
        if (lat != 2 || flt !== 1'b0 || rd !== 32'd0 || mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_basic: lat=%0d f=%b rd=0x%08h mem=0x%08h want 2/0/0/DEADBEEF",
                     lat, flt, rd, mem[4]);
        end
        do_op(1'b0, 3'd2, 9'h010, 32'h0, rd, flt, lat, sr, sw);
        checks++;
        if (lat != 2 || flt !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_basic: lat=%0d f=%b rd=0x%08h want 2/0/DEADBEEF", lat, flt, rd);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic flt, sr, sw; int lat;
        do_op(1'b1, 3'd2, 9'h010, 32'h11223344, rd, flt, lat, sr, sw);
        do_op(1'b1, 3'd0, 9'h013, 32'h12345680, rd, flt, lat, sr, sw);
        checks++;
        if (lat != 3 || flt !== 1'b0 || mem[4] !== 32'h80223344) begin
            errors++;
            $display("FAIL sb_merge: lat=%0d f=%b mem=0x%08h want 3/0/80223344", lat, flt, mem[4]);
        end
        do_op(1'b0, 3'd0, 9'h013, 32'h0, rd, flt, lat, sr, sw);
        checks++;
        if (rd !== 32'hFFFFFF80 || flt !== 1'b0) begin
            errors++; $display("FAIL lb_sign: got 0x%08h want FFFFFF80", rd);
        end
        do_op(1'b0, 3'd4, 9'h013, 32'h0, rd, flt, lat, sr, sw);
        checks++;
        if (rd !== 32'h00000080) begin
            errors++; $display("FAIL lbu_zero: got 0x%08h want 00000080", rd);
        end
        do_op(1'b0, 3'd0, 9'h012, 32'h0, rd, flt, lat, sr, sw);
        checks++;
        if (rd !== 32'h00000022) begin
            errors++; $display("FAIL lb_lane2: got 0x%08h want 00000022", rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic flt, sr, sw; int lat;
        do_op(1'b1, 3'd1, 9'h012, 32'hABCD8001, rd, flt, lat, sr, sw);
        checks++;
        if (lat != 3 || flt !== 1'b0 || mem[4] !== 32'h80013344) begin
            errors++;
            $display("FAIL sh_merge: lat=%0d f=%b mem=0x%08h want 3/0/80013344", lat, flt, mem[4]);
        end
        do_op(1'b0, 3'd1, 9'h012, 32'h0, rd, flt, lat, sr, sw);
        checks++;
        if (rd !== 32'hFFFF8001) begin
            errors++; $display("FAIL lh_sign: got 0x%08h want FFFF8001", rd);
        end
        do_op(1'b0, 3'd5, 9'h012, 32'h0, rd, flt, lat, sr, sw);
        checks++;
        if (rd !== 32'h00008001) begin
            errors++; $display("FAIL lhu_zero: got 0x%08h want 00008001", rd);
        end
        do_op(1'b0, 3'd1, 9'h010, 32'h0, rd, flt, lat, sr, sw);
        checks++;
        if (rd !== 32'h00003344) begin
            errors++; $display("FAIL lh_low: got 0x%08h want 00003344", rd);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd; logic flt, sr, sw; int lat;
        logic        st_v [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3_v [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
        logic [8:0]  a_v  [4] = '{9'h011, 9'h013, 9'h010, 9'h010};
        for (int i = 0; i < 4; i++) begin
            do_op(st_v[i], f3_v[i], a_v[i], 32'h5A5A5A5A, rd, flt, lat, sr, sw);
            checks++;
            if (flt !== 1'b1 || rd !== 32'd0 || lat != 1 || sr !== 1'b0 || sw !== 1'b0) begin
                errors++;
                $display("FAIL fault_%0d: f=%b rd=0x%08h lat=%0d mr=%b mw=%b want 1/0/1/0/0",
                         i, flt, rd, lat, sr, sw);
            end
        end
        checks++;
        if (mem[4] !== 32'h80013344) begin
            errors++; $display("FAIL fault_no_write: mem=0x%08h want 80013344", mem[4]);
        end
    endtask

    task automatic test_reset_mid_rmw();
        logic [31:0] rd; logic flt, sr, sw; int lat;
        do_op(1'b1, 3'd2, 9'h020, 32'hAABBCCDD, rd, flt, lat, sr, sw);
        @(negedge clk);
        req_store = 1'b1; req_funct3 = 3'd0; req_addr = 9'h021; req_wdata = 32'h99; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || mem_wdata !== 32'hAABB99DD) begin
            errors++;
            $display("FAIL rmw_wr_phase: mw=%b wdata=0x%08h want 1/AABB99DD", mem_write, mem_wdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort: mw=%b rv=%b ready=%b want 0/0/0", mem_write, resp_valid, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem[8] !== 32'hAABBCCDD) begin
            errors++; $display("FAIL rst_no_update: mem=0x%08h want AABBCCDD", mem[8]);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_idle: ready=%b rv=%b want 1/0", req_ready, resp_valid);
        end
        $display("txn reset during RMW_WR, word 0x020 = 0x%08h", mem[8]);
    endtask

    task automatic test_hold_and_top();
        logic [31:0] rd; logic flt, sr, sw; int lat;
        do_op(1'b1, 3'd2, 9'h1FC, 32'hCAFEF00D, rd, flt, lat, sr, sw);
        checks++;
        if (mem[127] !== 32'hCAFEF00D || flt !== 1'b0) begin
            errors++; $display("FAIL top_store: mem=0x%08h f=%b want CAFEF00D/0", mem[127], flt);
        end
        @(negedge clk);
        req_store = 1'b0; req_funct3 = 3'd2; req_addr = 9'h1FC; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_addr = 9'h010; req_funct3 = 3'd0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 2) begin
            errors++; $display("FAIL top_load_latency: got %0d want 2", lat);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D || resp_fault !== 1'b0
                || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: rv=%b rd=0x%08h f=%b ready=%b want 1/CAFEF00D/0/0",
                         i, resp_valid, resp_rdata, resp_fault, req_ready);
            end
            @(negedge clk);
        end
        $display("txn store=0 f3=2 addr=0x1fc held -> rdata=0x%08h fault=%0b", resp_rdata, resp_fault);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release: rv=%b ready=%b want 0/1", resp_valid, req_ready);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        test_reset();
        test_store_load();
        test_byte();
        test_half();
        test_faults();
        test_reset_mid_rmw();
        test_hold_and_top();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
